// File: rtl/occ_axil_responder_pkg.sv
// Shared types and constants for the occurrence-table AXI4-Lite responder.
// Also holds the byte-address to word-index decode helpers.
package occ_axil_responder_pkg;

    localparam int OCC_W     = 256;
    localparam int OCC_BYTES = 32;
    localparam int ADDR_W    = 40;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef logic [OCC_W-1:0] occ_word;

    // Word index relative to the table base; the low five address bits select a byte within the word.
    function automatic logic [ADDR_W-1:0] occ_word_index(input logic [ADDR_W-1:0] addr,
                                                         input logic [ADDR_W-1:0] base);
        return (addr - base) >> 5;
    endfunction

    function automatic logic occ_in_range(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base,
                                          input int              depth_log);
        return (addr >= base) && ((occ_word_index(addr, base) >> depth_log) == '0);
    endfunction

endpackage

// File: rtl/occ_axil_responder_bram.sv
// Single-port occurrence-word RAM with byte-write enable and MEM_LAT registered read stages.
module occ_axil_responder_bram
    import occ_axil_responder_pkg::*;
#(
    parameter int DEPTH_LOG = 14,
    parameter int MEM_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [OCC_BYTES-1:0] be,
    input  logic [DEPTH_LOG-1:0] addr,
    input  logic [OCC_W-1:0]     wdata,
    output logic [OCC_W-1:0]     rdata
);
    occ_word mem  [2**DEPTH_LOG];
    occ_word pipe [MEM_LAT];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < OCC_BYTES; b++) begin
                    if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                pipe[0] <= mem[addr];
            end
        end
        for (int s = 1; s < MEM_LAT; s++) pipe[s] <= pipe[s-1];
    end

    assign rdata = pipe[MEM_LAT-1];

endmodule

// File: rtl/occ_axil_responder.sv
// AXI4-Lite responder serving 256-bit occurrence-table words from on-chip RAM, one read per clock.
// OCC_AXIL_WRITE_EN enables RAM writes; otherwise every write completes with SLVERR.
module occ_axil_responder
    import occ_axil_responder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int DEPTH_LOG = 14,
    parameter int MEM_LAT   = 2,
    parameter int FIFO_LOG  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    s_araddr,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [OCC_W-1:0]     s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    input  logic [ADDR_W-1:0]    s_awaddr,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [OCC_W-1:0]     s_wdata,
    input  logic [OCC_BYTES-1:0] s_wstrb,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic [1:0]           s_bresp,
    output logic                 s_bvalid,
    input  logic                 s_bready
);
    localparam int FIFO_DEPTH = 2 ** FIFO_LOG;
    localparam int CW         = FIFO_LOG + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);
    localparam logic [FIFO_LOG-1:0] PTR_ONE = FIFO_LOG'(1);

    logic                 arready_q, accept, push, pop;
    logic                 ar_ok;
    logic [DEPTH_LOG-1:0] ar_idx, aw_idx, ram_addr;
    logic [MEM_LAT-1:0]   pipe_vld, pipe_ok;
    logic [CW-1:0]        credits, credits_n, fifo_cnt;
    logic [FIFO_LOG-1:0]  wr_ptr, rd_ptr;
    occ_word              fifo_data [FIFO_DEPTH];
    logic [1:0]           fifo_resp [FIFO_DEPTH];
    occ_word              ram_q;
    logic                 ram_en, wr_en, wr_go;

    logic                 aw_held, aw_held_n, w_held, w_held_n, bvalid_n;
    logic [1:0]           bresp_n, wr_resp;
    logic [ADDR_W-1:0]    aw_addr;
    occ_word              w_data;
    logic [OCC_BYTES-1:0] w_strb;

    assign wr_go = aw_held & w_held & ~s_bvalid;

`ifdef OCC_AXIL_WRITE_EN
    logic aw_ok;
    assign aw_ok     = occ_in_range(aw_addr, BASE_ADDR, DEPTH_LOG);
    assign wr_en     = wr_go & aw_ok;
    assign wr_resp   = aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    // The write owns the single RAM port for this cycle.
    assign s_arready = arready_q & ~wr_go;
`else
    assign wr_en     = 1'b0;
    assign wr_resp   = AXI_RESP_SLVERR;
    assign s_arready = arready_q;
`endif

    assign accept   = s_arvalid & s_arready;
    assign ar_ok    = occ_in_range(s_araddr, BASE_ADDR, DEPTH_LOG);
    assign ar_idx   = DEPTH_LOG'(occ_word_index(s_araddr, BASE_ADDR));
    assign aw_idx   = DEPTH_LOG'(occ_word_index(aw_addr, BASE_ADDR));
    assign ram_addr = wr_en ? aw_idx : ar_idx;
    assign ram_en   = (accept & ar_ok) | wr_en;

    occ_axil_responder_bram #(
        .DEPTH_LOG (DEPTH_LOG),
        .MEM_LAT   (MEM_LAT)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (wr_en),
        .be    (w_strb),
        .addr  (ram_addr),
        .wdata (w_data),
        .rdata (ram_q)
    );

    assign push     = pipe_vld[MEM_LAT-1];
    assign s_rvalid = (fifo_cnt != '0);
    assign pop      = s_rvalid & s_rready;
    assign s_rdata  = s_rvalid ? fifo_data[rd_ptr] : '0;
    assign s_rresp  = s_rvalid ? fifo_resp[rd_ptr] : AXI_RESP_OKAY;

    // Credits cover RAM-pipe plus FIFO occupancy so a push always finds a free slot.
    always_comb begin
        credits_n = credits;
        if (accept && !pop)      credits_n = credits + CREDIT_ONE;
        else if (!accept && pop) credits_n = credits - CREDIT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld  <= '0;
            pipe_ok   <= '0;
            credits   <= '0;
            arready_q <= 1'b0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            pipe_vld[0] <= accept;
            pipe_ok[0]  <= ar_ok;
            for (int s = 1; s < MEM_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_ok[s]  <= pipe_ok[s-1];
            end
            credits   <= credits_n;
            arready_q <= (credits_n < CREDIT_MAX);
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      fifo_cnt <= fifo_cnt + CREDIT_ONE;
            else if (!push && pop) fifo_cnt <= fifo_cnt - CREDIT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= pipe_ok[MEM_LAT-1] ? ram_q : '0;
            fifo_resp[wr_ptr] <= pipe_ok[MEM_LAT-1] ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
    end

    always_comb begin
        aw_held_n = aw_held;
        w_held_n  = w_held;
        bvalid_n  = s_bvalid;
        bresp_n   = s_bresp;
        if (s_awvalid && s_awready) aw_held_n = 1'b1;
        if (s_wvalid && s_wready)   w_held_n  = 1'b1;
        if (wr_go) begin
            aw_held_n = 1'b0;
            w_held_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = wr_resp;
        end
        if (s_bvalid && s_bready) bvalid_n = 1'b0;
    end

    // Ready stays low from capture until the B handshake completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= AXI_RESP_OKAY;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
        end else begin
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            s_bvalid  <= bvalid_n;
            s_bresp   <= bresp_n;
            s_awready <= ~aw_held_n & ~bvalid_n;
            s_wready  <= ~w_held_n & ~bvalid_n;
        end
    end

    always_ff @(posedge clk) begin
        if (s_awvalid && s_awready) aw_addr <= s_awaddr;
        if (s_wvalid && s_wready) begin
            w_data <= s_wdata;
            w_strb <= s_wstrb;
        end
    end

endmodule
